// File: rtl/vmx_result_collector.sv
// vmx_result_collector: de-skews the row products leaving the systolic array,
// aligns them into one vector per issued input, buffers the vectors in a FIFO
// and presents them on a valid/ready stream. A credit output keeps the
// non-stallable array from ever producing a result with nowhere to go.
module vmx_result_collector #(
    parameter int ARRAY_SIZE     = 4,
    parameter int PRODUCT_BITLEN = 32,
    parameter int BASE_LAT       = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 issue,
    output logic                                 issue_ready,
    input  logic [PRODUCT_BITLEN*ARRAY_SIZE-1:0] product,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [PRODUCT_BITLEN*ARRAY_SIZE-1:0] m_data,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
    output logic                                 overflow
);

    localparam int W      = PRODUCT_BITLEN * ARRAY_SIZE;
    localparam int SR_LEN = BASE_LAT + ARRAY_SIZE - 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    logic [SR_LEN-1:0] issue_sr;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  inflight;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [W-1:0]      mem [FIFO_DEPTH];
    logic [W-1:0]      aligned;

    logic              accept;
    logic              wr_en;
    logic              wr_ok;
    logic              pop;
    logic [LVL_W-1:0]  level_n;
    logic [PTR_W-1:0]  rd_ptr_n;
    logic [W-1:0]      head_n;

    // Row i waits ARRAY_SIZE-1-i cycles so every row lines up with the last one.
    for (genvar i = 0; i < ARRAY_SIZE - 1; i++) begin : g_row
        logic [PRODUCT_BITLEN-1:0] stage [ARRAY_SIZE-1-i];

        // Per-row delay chain, cleared on reset so stale samples cannot leak out.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned s = 0; s < ARRAY_SIZE - 1 - i; s++) begin
                    stage[s] <= '0;
                end
            end else begin
                stage[0] <= product[i*PRODUCT_BITLEN +: PRODUCT_BITLEN];
                for (int unsigned s = 1; s < ARRAY_SIZE - 1 - i; s++) begin
                    stage[s] <= stage[s-1];
                end
            end
        end

        assign aligned[i*PRODUCT_BITLEN +: PRODUCT_BITLEN] = stage[ARRAY_SIZE-2-i];
    end

    assign aligned[(ARRAY_SIZE-1)*PRODUCT_BITLEN +: PRODUCT_BITLEN] =
        product[(ARRAY_SIZE-1)*PRODUCT_BITLEN +: PRODUCT_BITLEN];

    assign issue_ready = ({1'b0, level} + {1'b0, inflight}) < (LVL_W+1)'(FIFO_DEPTH);
    assign accept      = issue && issue_ready;
    assign wr_en       = issue_sr[SR_LEN-1];
    assign pop         = m_valid && m_ready;
    assign wr_ok       = wr_en && ((level != LVL_W'(FIFO_DEPTH)) || pop);
    assign fifo_level  = level;

    // Next FIFO head: the word being written this edge if it becomes the only
    // entry, otherwise the stored word at the advanced read pointer.
    always_comb begin
        level_n  = level + LVL_W'(wr_ok) - LVL_W'(pop);
        rd_ptr_n = rd_ptr + PTR_W'(pop);
        head_n   = m_data;
        if (wr_ok && (level_n == LVL_W'(1))) begin
            head_n = aligned;
        end else if (level_n != '0) begin
            head_n = mem[rd_ptr_n];
        end
    end

    // FIFO storage; contents need no reset because the level gates validity.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= aligned;
        end
    end

    // Issue tracking, credit accounting, pointers and the registered output head.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_sr <= '0;
            inflight <= '0;
            level    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            overflow <= 1'b0;
        end else begin
            issue_sr <= {issue_sr[SR_LEN-2:0], accept};
            inflight <= inflight + LVL_W'(accept) - LVL_W'(wr_en);
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr  <= rd_ptr_n;
            level   <= level_n;
            m_valid <= (level_n != '0);
            m_data  <= head_n;
            if ((issue && !issue_ready) || (wr_en && !wr_ok)) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vmx_result_collector.sv
// Randomised bench for vmx_result_collector with a queue-based reference model.
module tb_vmx_result_collector;

    localparam int AS   = 4;
    localparam int PB   = 32;
    localparam int BL   = 4;
    localparam int FD   = 8;
    localparam int W    = AS * PB;
    localparam int LAT  = BL + AS - 1;
    localparam int MAXC = 4096;

    logic         clk = 1'b0;
    logic         rst;
    logic         issue;
    logic         issue_ready;
    logic [W-1:0] product;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic [3:0]   fifo_level;
    logic         overflow;

    always #5 clk = ~clk;

    vmx_result_collector #(
        .ARRAY_SIZE(AS),
        .PRODUCT_BITLEN(PB),
        .BASE_LAT(BL),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .issue(issue),
        .issue_ready(issue_ready),
        .product(product),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .fifo_level(fifo_level),
        .overflow(overflow)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit live     = 1'b0;
    bit junk_dead;

    logic [W-1:0] plan_vec [MAXC];
    bit           plan_iss [MAXC];

    typedef struct {
        int           wc;
        logic [W-1:0] v;
    } pend_t;

    pend_t        pend[$];
    logic [W-1:0] stored[$];
    bit           m_ovf;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: results leave in issue order, LAT cycles after issue,
    // subject to credit = stored + in-flight < FD.
    always @(posedge clk) begin : model
        bit    rdy;
        bit    popm;
        pend_t p;
        if (rst) begin
            pend.delete();
            stored.delete();
            m_ovf = 1'b0;
            live  = 1'b1;
        end else if (live) begin
            rdy  = (stored.size() + pend.size()) < FD;
            popm = (stored.size() != 0) && m_ready;
            if (popm) void'(stored.pop_front());
            if (pend.size() != 0 && pend[0].wc == cyc) begin
                p = pend.pop_front();
                if (stored.size() < FD) stored.push_back(p.v);
                else m_ovf = 1'b1;
            end
            if (issue) begin
                if (rdy) pend.push_back('{cyc + LAT, plan_vec[cyc]});
                else m_ovf = 1'b1;
            end
        end
        cyc++;
    end

    // Compare process: every cycle, mid-period.
    logic [W-1:0] prev_data;
    bit           prev_hold = 1'b0;
    always @(negedge clk) begin
        if (live) begin
            chk("m_valid", {127'd0, m_valid}, {127'd0, stored.size() != 0});
            chk("fifo_level", W'(fifo_level), W'(stored.size()));
            chk("issue_ready", {127'd0, issue_ready}, {127'd0, (stored.size() + pend.size()) < FD});
            chk("overflow", {127'd0, overflow}, {127'd0, m_ovf});
            if (stored.size() != 0) chk("m_data", m_data, stored[0]);
            if (prev_hold) chk("m_data_hold", m_data, prev_data);
            prev_hold = m_valid && !m_ready && !rst;
            prev_data = m_data;
        end
    end

    function automatic logic [W-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one cycle of stimulus; returns #1 after the closing edge.
    task automatic cycle(input bit iss, input bit rdy, input logic [W-1:0] vec);
        int src;
        issue         = iss;
        m_ready       = rdy;
        plan_iss[cyc] = iss;
        plan_vec[cyc] = vec;
        for (int i = 0; i < AS; i++) begin
            src = cyc - BL - i;
            if (src >= 0 && plan_iss[src]) product[i*PB +: PB] = plan_vec[src][i*PB +: PB];
            else product[i*PB +: PB] = junk_dead ? 32'hDEAD : $urandom;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] v;
        int           n;
        bit           iss;
        rst       = 1'b1;
        issue     = 1'b0;
        m_ready   = 1'b0;
        product   = '0;
        junk_dead = 1'b1;
        cycle(0, 0, '0);
        cycle(0, 0, '0);
        rst = 1'b0;

        chk("rst_m_valid", {127'd0, m_valid}, '0);
        chk("rst_m_data", m_data, '0);
        chk("rst_fifo_level", W'(fifo_level), '0);
        chk("rst_overflow", {127'd0, overflow}, '0);
        chk("rst_issue_ready", {127'd0, issue_ready}, W'(1));

        // Single issue, junk 0xDEAD elsewhere.
        while (cyc < 10) cycle(0, 1, '0);
        cycle(1, 1, {32'h103, 32'h102, 32'h101, 32'h100});
        repeat (6) cycle(0, 1, '0);
        chk("single_before", {127'd0, m_valid}, '0);
        cycle(0, 1, '0);
        chk("single_valid", {127'd0, m_valid}, W'(1));
        chk("single_data", m_data, 128'h00000103_00000102_00000101_00000100);
        cycle(0, 1, '0);
        chk("single_once", {127'd0, m_valid}, '0);

        // Back-to-back issues, one word per cycle with no gaps.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < AS; i++) v[i*PB +: PB] = 32'(16 * k + i);
            cycle(1, 1, v);
        end
        for (int k = 0; k < 8; k++) begin
            chk("b2b_valid", {127'd0, m_valid}, W'(1));
            chk("b2b_lane0", W'(m_data[PB-1:0]), W'(16 * k));
            cycle(0, 1, '0);
        end
        chk("b2b_end", {127'd0, m_valid}, '0);
        junk_dead = 1'b0;

        // Credit at full.
        repeat (10) cycle(0, 1, '0);
        repeat (8) cycle(1, 0, rand_vec());
        chk("credit_low", {127'd0, issue_ready}, '0);
        chk("no_overflow_yet", {127'd0, overflow}, '0);
        cycle(1, 0, rand_vec());
        chk("overflow_set", {127'd0, overflow}, W'(1));
        repeat (8) cycle(0, 0, '0);
        chk("level_full", W'(fifo_level), W'(8));
        repeat (12) cycle(0, 1, '0);
        chk("drained", W'(fifo_level), '0);

        // Backpressure: toggling ready, then random ready, frequent issues.
        for (int c = 0; c < 100; c++) cycle(($urandom % 4) != 0, c[0], rand_vec());
        for (int c = 0; c < 200; c++) cycle(($urandom % 4) != 0, ($urandom % 2) != 0, rand_vec());

        // Wrap-around: 20 credit-obeying vectors through the FIFO.
        n = 0;
        while (n < 20) begin
            iss = issue_ready && (($urandom % 2) != 0);
            n += int'(iss);
            cycle(iss, ($urandom % 4) != 0, rand_vec());
        end
        repeat (20) cycle(0, 1, '0);
        chk("wrap_drained", W'(fifo_level), '0);

        // Reset mid-flight: in-flight results and their late products are ignored.
        repeat (3) cycle(1, 1, rand_vec());
        repeat (2) cycle(0, 1, '0);
        rst = 1'b1;
        cycle(0, 1, '0);
        rst = 1'b0;
        repeat (20) begin
            chk("mid_rst_valid", {127'd0, m_valid}, '0);
            chk("mid_rst_level", W'(fifo_level), '0);
            chk("mid_rst_overflow", {127'd0, overflow}, '0);
            chk("mid_rst_ready", {127'd0, issue_ready}, W'(1));
            cycle(0, 1, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
